// File: rtl/envelope_peak_detector_if.sv
// AXI-Stream style valid/ready channel used by the envelope peak detector.
// Ports (signals):
//   tdata  - payload, TDATA_W bits
//   tvalid - payload valid (driven by master)
//   tready - sink ready (driven by slave)
// Modports: master (drives tdata/tvalid), slave (drives tready).
interface envelope_peak_detector_if #(
  parameter int unsigned TDATA_W = 32
) ();
  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/envelope_peak_detector.sv
// Local-maximum detector for a decimated, signed envelope stream.
// A peak is the last rising sample before the first falling sample; plateaus keep
// their first index. Peaks must reach a signed threshold and be at least
// `refractory` samples after the previously emitted peak.
// Ports:
//   aclk, aresetn  - clock, asynchronous active-low reset
//   s_axis_data    - sample input stream (slave, always ready after reset)
//   threshold      - signed minimum peak amplitude
//   refractory     - minimum index distance between emitted peaks
//   clear          - synchronous restart of detection
//   m_axis_peak    - peak output stream, tdata = {index, value}
//   overflow       - sticky flag: a qualifying peak was dropped
//   drop_count     - saturating count of dropped peaks
module envelope_peak_detector #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  envelope_peak_detector_if.slave  s_axis_data,
  input  logic [DATA_W-1:0]        threshold,
  input  logic [IDX_W-1:0]         refractory,
  input  logic                     clear,
  envelope_peak_detector_if.master m_axis_peak,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  typedef enum logic [1:0] {StInit, StFall, StRise} state_e;

  state_e              r_state, w_state_d;
  logic                r_tready;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_prev;
  logic [IDX_W-1:0]    r_cand_idx;
  logic [DATA_W-1:0]   r_cand_val;
  logic [IDX_W-1:0]    r_last_idx;
  logic                r_no_peak;
  logic                r_tvalid;
  logic [IDX_W+DATA_W-1:0] r_tdata;
  logic                r_overflow;
  logic [15:0]         r_drop_count;

  logic [DATA_W-1:0]   w_x;
  logic                w_accept;
  logic                w_gt;
  logic                w_lt;
  logic                w_peak_event;
  logic [IDX_W-1:0]    w_dist;
  logic                w_qualify;
  logic                w_hs;
  logic                w_load;
  logic                w_drop;

  assign w_x      = s_axis_data.tdata;
  assign w_accept = s_axis_data.tvalid & r_tready & ~clear;
  assign w_gt     = $signed(w_x) > $signed(r_prev);
  assign w_lt     = $signed(w_x) < $signed(r_prev);

  // Modular distance so refractory works across index wrap.
  assign w_dist    = r_cand_idx - r_last_idx;
  assign w_qualify = w_peak_event && ($signed(r_cand_val) >= $signed(threshold)) &&
                     (r_no_peak || (w_dist >= refractory));
  assign w_hs      = r_tvalid & m_axis_peak.tready;
  // Output register is free if empty or being emptied this very cycle.
  assign w_load    = w_qualify & (~r_tvalid | w_hs);
  assign w_drop    = w_qualify & ~w_load;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_peak_event = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        StInit: w_state_d = StFall;
        StFall: if (w_gt) w_state_d = StRise;
        StRise: begin
          if (w_lt) begin
            w_state_d    = StFall;
            w_peak_event = 1'b1;
          end
        end
        default: w_state_d = StInit;
      endcase
    end
    if (clear) begin
      w_state_d = StInit;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tready     <= 1'b0;
      r_idx        <= '0;
      r_prev       <= '0;
      r_cand_idx   <= '0;
      r_cand_val   <= '0;
      r_last_idx   <= '0;
      r_no_peak    <= 1'b1;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_tready <= 1'b1;
      if (clear) begin
        r_idx        <= '0;
        r_no_peak    <= 1'b1;
        r_tvalid     <= 1'b0;
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end else begin
        if (w_accept) begin
          r_prev <= w_x;
          r_idx  <= r_idx + 1'b1;
          if ((r_state != StInit) && w_gt) begin
            r_cand_idx <= r_idx;
            r_cand_val <= w_x;
          end
        end
        if (w_load) begin
          r_tdata    <= {r_cand_idx, r_cand_val};
          r_tvalid   <= 1'b1;
          r_last_idx <= r_cand_idx;
          r_no_peak  <= 1'b0;
        end else if (w_hs) begin
          r_tvalid <= 1'b0;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
          end
        end
      end
    end
  end

  assign s_axis_data.tready = r_tready;
  assign m_axis_peak.tdata  = r_tdata;
  assign m_axis_peak.tvalid = r_tvalid;
  assign overflow           = r_overflow;
  assign drop_count         = r_drop_count;

endmodule

// File: tb/tb_envelope_peak_detector.sv
// Directed table-driven bench for envelope_peak_detector.
module tb_envelope_peak_detector;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 32;

  logic              aclk;
  logic              aresetn;
  logic [DATA_W-1:0] threshold;
  logic [IDX_W-1:0]  refractory;
  logic              clear;
  logic              overflow;
  logic [15:0]       drop_count;

  envelope_peak_detector_if #(.TDATA_W(DATA_W))         s_if ();
  envelope_peak_detector_if #(.TDATA_W(IDX_W + DATA_W)) m_if ();

  envelope_peak_detector #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axis_data(s_if),
    .threshold  (threshold),
    .refractory (refractory),
    .clear      (clear),
    .m_axis_peak(m_if),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    string       name;
    logic        clr;
    logic        vld;
    logic [31:0] data;
    logic [31:0] thr;
    logic [31:0] refr;
    logic        rdy;
    logic        exp_vld;
    logic [31:0] exp_idx;
    logic [31:0] exp_val;
    logic        exp_ovf;
    logic [15:0] exp_drop;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string name, logic clr, logic vld, logic [31:0] data,
                              logic [31:0] thr, logic [31:0] refr, logic rdy,
                              logic exp_vld, logic [31:0] exp_idx, logic [31:0] exp_val,
                              logic exp_ovf, logic [15:0] exp_drop);
    vec_t v;
    v.name = name; v.clr = clr; v.vld = vld; v.data = data; v.thr = thr; v.refr = refr;
    v.rdy = rdy; v.exp_vld = exp_vld; v.exp_idx = exp_idx; v.exp_val = exp_val;
    v.exp_ovf = exp_ovf; v.exp_drop = exp_drop;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v);
    clear          = v.clr;
    s_if.tvalid    = v.vld;
    s_if.tdata     = v.data;
    threshold      = v.thr;
    refractory     = v.refr;
    m_if.tready    = v.rdy;
    @(posedge aclk);
    #1;
    chk({v.name, ".tvalid"}, 64'(m_if.tvalid), 64'(v.exp_vld));
    if (v.exp_vld) chk({v.name, ".tdata"}, m_if.tdata, {v.exp_idx, v.exp_val});
    chk({v.name, ".overflow"}, 64'(overflow), 64'(v.exp_ovf));
    chk({v.name, ".drop"}, 64'(drop_count), 64'(v.exp_drop));
  endtask

  localparam logic [31:0] T  = 32'h800;
  localparam logic [31:0] TA = 32'hA00;

  initial begin
    // Basic peak, latency 1
    vecs.push_back(mk("a0", 0, 1, 32'h100, T, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("a1", 0, 1, 32'h900, T, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("a2", 0, 1, 32'hC00, T, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("a3", 0, 1, 32'h700, T, 0, 1, 1, 2, 32'hC00, 0, 0));
    vecs.push_back(mk("aclr", 1, 1, 32'h5000, T, 0, 1, 0, 0, 0, 0, 0));
    // Plateau keeps first index; peak equal to threshold qualifies
    vecs.push_back(mk("p0", 0, 1, 32'h900, TA, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p1", 0, 1, 32'hA00, TA, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p2", 0, 1, 32'hA00, TA, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p3", 0, 1, 32'h500, TA, 0, 1, 1, 1, 32'hA00, 0, 0));
    vecs.push_back(mk("pbub", 0, 0, 32'hFFF, TA, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p4", 0, 1, 32'h100, TA, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p5", 0, 1, 32'h700, TA, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("p6", 0, 1, 32'h100, TA, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("pclr", 1, 0, 32'h0, T, 0, 1, 0, 0, 0, 0, 0));
    // Signed comparison: negative first sample
    vecs.push_back(mk("s0", 0, 1, 32'hFFFFFF00, T, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s1", 0, 1, 32'h900, T, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s2", 0, 1, 32'h200, T, 0, 1, 1, 1, 32'h900, 0, 0));
    vecs.push_back(mk("s3", 0, 1, 32'h200, T, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sclr", 1, 0, 32'h0, T, 0, 1, 0, 0, 0, 0, 0));
    // Refractory 5: peaks at 2, 5, 8 -> 5 discarded
    vecs.push_back(mk("r0", 0, 1, 32'h100, T, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r1", 0, 1, 32'h900, T, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r2", 0, 1, 32'hC00, T, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r3", 0, 1, 32'h700, T, 5, 1, 1, 2, 32'hC00, 0, 0));
    vecs.push_back(mk("r4", 0, 1, 32'h900, T, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r5", 0, 1, 32'hB00, T, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r6", 0, 1, 32'h600, T, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r7", 0, 1, 32'h900, T, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r8", 0, 1, 32'hD00, T, 5, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("r9", 0, 1, 32'h500, T, 5, 1, 1, 8, 32'hD00, 0, 0));
    vecs.push_back(mk("rclr", 1, 0, 32'h0, T, 0, 1, 0, 0, 0, 0, 0));
    // Backpressure: second peak dropped, first held
    vecs.push_back(mk("o0", 0, 1, 32'h100, T, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("o1", 0, 1, 32'h900, T, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("o2", 0, 1, 32'h400, T, 0, 0, 1, 1, 32'h900, 0, 0));
    vecs.push_back(mk("o3", 0, 1, 32'hA00, T, 0, 0, 1, 1, 32'h900, 0, 0));
    vecs.push_back(mk("o4", 0, 1, 32'h300, T, 0, 0, 1, 1, 32'h900, 1, 1));
    vecs.push_back(mk("o5", 0, 0, 32'h0, T, 0, 0, 1, 1, 32'h900, 1, 1));
    vecs.push_back(mk("oclr", 1, 0, 32'h0, T, 0, 0, 0, 0, 0, 0, 0));
    // New peak in the same cycle as the handshake replaces the old one
    vecs.push_back(mk("h0", 0, 1, 32'h100, T, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("h1", 0, 1, 32'h900, T, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("h2", 0, 1, 32'h400, T, 0, 0, 1, 1, 32'h900, 0, 0));
    vecs.push_back(mk("h3", 0, 1, 32'hA00, T, 0, 0, 1, 1, 32'h900, 0, 0));
    vecs.push_back(mk("h4", 0, 1, 32'h300, T, 0, 1, 1, 3, 32'hA00, 0, 0));
    vecs.push_back(mk("h5", 0, 1, 32'h200, T, 0, 1, 0, 0, 0, 0, 0));

    aresetn     = 1'b0;
    clear       = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    threshold   = T;
    refractory  = '0;
    #1;
    chk("rst.tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst.tdata", m_if.tdata, 64'd0);
    chk("rst.overflow", 64'(overflow), 64'd0);
    chk("rst.drop", 64'(drop_count), 64'd0);
    chk("rst.tready", 64'(s_if.tready), 64'd0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst.tready", 64'(s_if.tready), 64'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Async reset while a peak is pending
    run_vec(mk("m0", 0, 1, 32'h100, T, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mk("m1", 0, 1, 32'h900, T, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mk("m2", 0, 1, 32'h400, T, 0, 0, 1, 7, 32'h900, 0, 0));
    s_if.tvalid = 1'b0;
    #3;
    aresetn = 1'b0;
    #1;
    chk("arst.tvalid", 64'(m_if.tvalid), 64'd0);
    chk("arst.tdata", m_if.tdata, 64'd0);
    chk("arst.tready", 64'(s_if.tready), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("arst_rel.tready", 64'(s_if.tready), 64'd1);
    run_vec(mk("n0", 0, 1, 32'h100, T, 0, 1, 0, 0, 0, 0, 0));
    run_vec(mk("n1", 0, 1, 32'h900, T, 0, 1, 0, 0, 0, 0, 0));
    run_vec(mk("n2", 0, 1, 32'h400, T, 0, 1, 1, 1, 32'h900, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
